dff_to_tff_counter: RTL and testbench
=====================================

# dff_to_tff_counter

Bank of WIDTH T flip-flops, each built from a D register whose next state is d = t ^ q. The bank runs either as a raw T-flip-flop array driven by an external toggle vector, or as a synchronous up/down binary counter with internally generated toggles. It is the D-to-T counterpart of the T-to-D conversion. It is the T-storage primitive for the counters and frequency dividers in the sequential-circuits section.

## Interface
Parameters:
- WIDTH, 4, number of T stages (≥1)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-low reset, sampled on rising clk
- en  input  1  global toggle enable; 0 holds state (load still allowed)
- cnt_mode  input  1  1 = counter mode, 0 = raw T mode
- up  input  1  counter direction, 1 = up, 0 = down (ignored when cnt_mode=0)
- t_in  input  WIDTH  per-bit toggle request in raw T mode
- load  input  1  synchronous parallel load
- din  input  WIDTH  load value
- q  output  WIDTH  registered state
- qb  output  WIDTH  ~q, always the exact complement
- tc  output  1  terminal count, combinational
- wrap  output  1  registered one-cycle pulse after a counter wrap

## Operation
- Storage: WIDTH D registers plus one wrap register. Every state bit updates only as q[i] <= q[i] ^ t[i], except on reset and load.
- Toggle vector t, in priority order:
  - Load or reset: t is unused.
  - en=0: t = 0.
  - cnt_mode=0: t = t_in.
  - cnt_mode=1, up=1: t[0]=1; t[i] = &q[i-1:0].
  - cnt_mode=1, up=0: t[0]=1; t[i] = &qb[i-1:0].
- Priority on each rising edge: rst=0 > load=1 > toggle.
  - rst=0: q <= 0, wrap <= 0.
  - load=1: q <= din, wrap <= 0, regardless of en or mode.
  - Otherwise: q <= q ^ t.
- tc = en & cnt_mode & (up ? (q == all-ones) : (q == 0)). tc is 0 in raw T mode and 0 while en=0.
- wrap <= tc & ~load & rst. It is high exactly in the cycle after q goes all-ones→0 (up) or 0→all-ones (down).
- Arithmetic is modulo 2^WIDTH with no saturation.
- A mode or direction change takes effect on the next edge, with no extra state.
- Raw T mode with t_in all-ones inverts q each cycle.
- Raw T mode with t_in = 0 holds q.

## Timing
- Reset values: q = 0, qb = all-ones, tc = 0, wrap = 0.
- Reset is active on the first edge where rst=0, regardless of load, en or mode. Reset mid-count discards the count.
- Latency:
  - q and qb change one edge after the inputs are sampled.
  - tc follows q and the control inputs combinationally in the same cycle.
  - wrap lags tc by one edge.
- load concurrent with en=1 and tc=1: the load wins, q = din, wrap stays 0 on the next cycle.
- WIDTH=1 degenerates to a single T flip-flop: in counter mode q toggles every enabled cycle, and tc = en & (up ? q : ~q).
- No combinational path from t_in or din to q. Only tc is combinational.

## Test plan
- Reset:
  - Stimulus: rst=0 for 2 cycles with load=1, din=4'hA.
  - Required: q=0, qb=4'hF, tc=0, wrap=0.
  - Then release rst with en=0; q holds 0.
- Up count and wrap (WIDTH=4):
  - Stimulus: cnt_mode=1, up=1, en=1 from q=0 for 17 cycles.
  - Required: q runs 0,1,…,15,0,1; tc high only while q=15; wrap high only in the cycle where q=0 following 15.
- Down count:
  - Stimulus: load din=4'h2, then up=0, en=1.
  - Required: q = 2,1,0,15,14; tc high while q=0; wrap pulses when q=15.
- Raw T mode:
  - Stimulus: cnt_mode=0, q=4'b0000, then t_in = 4'b0101, 4'b0101, 4'b1111, 4'b0000.
  - Required: q = 4'b0101, 4'b0000, 4'b1111, 4'b1111; tc=0 throughout; qb == ~q every cycle.
- Priority collisions:
  - At q=15, up, en=1, assert load with din=4'h7: next q=7, wrap=0.
  - Then assert rst=0 and load together: next q=0.
  - With en=0 and load=1, din=4'h3: q=3.
- Direction flip mid-count:
  - Stimulus: count up to q=5, set up=0 for 3 cycles, then up=1.
  - Required: q = 5,4,3,2,3. Also check WIDTH=1: q alternates 0,1,0 with wrap pulsing after each 1→0.

Source files
------------

// File: rtl/dff_to_tff_counter.sv
// Bank of T flip-flops built from D registers (d = t ^ q), usable as a raw
// T array or as an up/down binary counter with internally generated toggles.

module dff_to_tff_stage (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic din,
  input  logic t,
  output logic q
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q ^ t;
    if (load) q_d = din;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= 1'b0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

module dff_to_tff_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cnt_mode,
  input  logic             up,
  input  logic [WIDTH-1:0] t_in,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] t;
  logic             carry;
  logic             wrap_q, wrap_d;

  // Counter toggles: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    t     = '0;
    carry = 1'b1;
    if (en) begin
      if (!cnt_mode) begin
        t = t_in;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          t[i]  = carry;
          carry = carry & (up ? q[i] : ~q[i]);
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    dff_to_tff_stage u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .din  (din[i]),
      .t    (t[i]),
      .q    (q[i])
    );
  end

  assign qb = ~q;
  assign tc = en & cnt_mode & (up ? (&q) : ~(|q));

  always_comb begin
    wrap_d = tc & ~load;
  end

  always_ff @(posedge clk) begin
    if (!rst) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
endmodule

// File: tb/tb_dff_to_tff_counter.sv
// Randomized and directed bench for dff_to_tff_counter (WIDTH=4 and WIDTH=1)
// against an arithmetic reference model.

module tb_dff_to_tff_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, cnt_mode, up, load;
  logic [3:0] t_in, din, q, qb;
  logic       tc, wrap;
  logic       q1, qb1, tc1, wrap1;

  int checks = 0, failures = 0;
  int m_q = 0, m_w = 0, m1_q = 0, m1_w = 0;
  bit armed = 0;

  dff_to_tff_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_mode(cnt_mode), .up(up),
    .t_in(t_in), .load(load), .din(din), .q(q), .qb(qb), .tc(tc), .wrap(wrap)
  );

  dff_to_tff_counter #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .cnt_mode(cnt_mode), .up(up),
    .t_in(t_in[0]), .load(load), .din(din[0]), .q(q1), .qb(qb1), .tc(tc1), .wrap(wrap1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter arithmetic modulo 2^W, raw mode XOR.
  function automatic int m_tc(input int qv, input int mask);
    return (en && cnt_mode && (up ? (qv == mask) : (qv == 0))) ? 1 : 0;
  endfunction

  function automatic int m_next(input int qv, input int mask, input int tv, input int dv);
    if (!rst)          return 0;
    if (load)          return dv & mask;
    if (!en)           return qv;
    if (!cnt_mode)     return (qv ^ tv) & mask;
    if (up)            return (qv + 1) & mask;
    return (qv - 1) & mask;
  endfunction

  function automatic int m_wrap(input int qv, input int mask);
    return (rst && !load && m_tc(qv, mask) != 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    m_w  <= m_wrap(m_q, 15);
    m_q  <= m_next(m_q, 15, int'(t_in), int'(din));
    m1_w <= m_wrap(m1_q, 1);
    m1_q <= m_next(m1_q, 1, int'(t_in[0]), int'(din[0]));
    armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("q", int'(q), m_q);
      chk("qb", int'(qb), (~m_q) & 15);
      chk("tc", int'(tc), m_tc(m_q, 15));
      chk("wrap", int'(wrap), m_w);
      chk("q1", int'(q1), m1_q);
      chk("qb1", int'(qb1), (~m1_q) & 1);
      chk("tc1", int'(tc1), m_tc(m1_q, 1));
      chk("wrap1", int'(wrap1), m1_w);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; load = 1; din = 4'hA; en = 0; cnt_mode = 0; up = 1; t_in = 4'h0;
    cyc(); cyc();
    chk("rst_q", int'(q), 0);
    chk("rst_qb", int'(qb), 15);
    chk("rst_tc", int'(tc), 0);
    chk("rst_wrap", int'(wrap), 0);
    rst = 1; load = 0;
    cyc();
    chk("hold_q", int'(q), 0);

    // Up count with wrap
    cnt_mode = 1; up = 1; en = 1;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      chk("up_q", int'(q), k % 16);
      chk("up_wrap", int'(wrap), (k == 16) ? 1 : 0);
      if (k == 15) chk("up_tc15", int'(tc), 1);
    end

    // Down count
    load = 1; din = 4'h2;
    cyc(); chk("dn_load", int'(q), 2);
    load = 0; up = 0;
    cyc(); chk("dn_q1", int'(q), 1);
    cyc(); chk("dn_q0", int'(q), 0); chk("dn_tc", int'(tc), 1);
    cyc(); chk("dn_q15", int'(q), 15); chk("dn_wrap", int'(wrap), 1);
    cyc(); chk("dn_q14", int'(q), 14); chk("dn_wrap_off", int'(wrap), 0);

    // Raw T mode
    load = 1; din = 4'h0;
    cyc();
    load = 0; cnt_mode = 0;
    t_in = 4'b0101; cyc(); chk("raw1", int'(q), 5);
    t_in = 4'b0101; cyc(); chk("raw2", int'(q), 0);
    t_in = 4'b1111; cyc(); chk("raw3", int'(q), 15);
    t_in = 4'b0000; cyc(); chk("raw4", int'(q), 15); chk("raw_tc", int'(tc), 0);

    // Priority collisions
    load = 1; din = 4'hF; cyc();
    load = 0; cnt_mode = 1; up = 1; en = 1;
    #1 chk("pri_tc", int'(tc), 1);
    load = 1; din = 4'h7;
    cyc(); chk("pri_load_q", int'(q), 7); chk("pri_load_wrap", int'(wrap), 0);
    rst = 0; load = 1;
    cyc(); chk("pri_rst_q", int'(q), 0);
    rst = 1; en = 0; load = 1; din = 4'h3;
    cyc(); chk("pri_en0_load", int'(q), 3);

    // Direction flip
    load = 1; din = 4'h0; cyc();
    load = 0; en = 1; up = 1; cnt_mode = 1;
    for (int k = 0; k < 5; k++) cyc();
    chk("flip_q5", int'(q), 5);
    up = 0;
    cyc(); chk("flip_q4", int'(q), 4);
    cyc(); chk("flip_q3", int'(q), 3);
    cyc(); chk("flip_q2", int'(q), 2);
    up = 1;
    cyc(); chk("flip_q3b", int'(q), 3);

    // WIDTH=1 single T flip-flop
    load = 1; din = 4'h0; cyc();
    load = 0;
    cyc(); chk("w1_q1", int'(q1), 1); chk("w1_wrap0", int'(wrap1), 0);
    cyc(); chk("w1_q0", int'(q1), 0); chk("w1_wrap1", int'(wrap1), 1);
    cyc(); chk("w1_q1b", int'(q1), 1); chk("w1_wrap0b", int'(wrap1), 0);

    // Randomized phase
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 31) != 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 4) != 0);
      cnt_mode = ($urandom_range(0, 2) != 0);
      up       = ($urandom_range(0, 3) != 0);
      t_in     = 4'($urandom);
      din      = 4'($urandom);
      cyc();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
